trap_responder: RTL and testbench
=================================

Name: trap_responder

Overview:
- Responder end of the pipeline's exception interface. The CPU raises an exception with a PC (sepc) and a cause (scause), and holds it until this block acknowledges.
- The block latches sepc/scause, flushes the pipeline for a fixed drain window, and redirects fetch to the trap handler.
- It tracks the handler period and, on a return request, redirects fetch to the instruction after the faulting one.
- Sits beside the CPU top; its redirect and flush outputs feed the IF stage and the pipeline-register flush controls.

Parameters:
- PC_W, 15, PC width (matches the pipeline PC).
- CAUSE_W, 32, cause width.
- HANDLER_BASE, 15'h0100, handler base address.
- VECTORED, 1, if 1: target = HANDLER_BASE + 4*scause[3:0]; if 0: target = HANDLER_BASE.
- DRAIN_CYCLES, 3, flush cycles before redirect; legal range 1..15.
- CNT_W, 8, width of the exception counter.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset, sampled on rising clk
- exc_valid  in  1  exception request; CPU holds it high until exc_ack
- exc_sepc  in  PC_W  faulting PC
- exc_scause  in  CAUSE_W  cause code
- sret_req  in  1  single-cycle return-from-handler request
- exc_ack  out  1  one-cycle acknowledge
- flush_all  out  1  flush every pipeline register
- trap_redirect  out  1  one-cycle fetch redirect strobe
- trap_target  out  PC_W  redirect address, valid while trap_redirect=1
- in_handler  out  1  high while executing the handler
- sepc_q  out  PC_W  latched sepc
- scause_q  out  CAUSE_W  latched scause
- exc_count  out  CNT_W  saturating count of accepted exceptions
- double_fault  out  1  sticky; set when an exception arrives during the handler

Behaviour:
- Reset, when reset_n=0 at a clk edge:
  - state=IDLE.
  - All outputs are 0 and all registers are cleared, including sepc_q, scause_q, exc_count and double_fault.
  - Reset mid-operation aborts any state immediately; no redirect is emitted.
- All outputs are registered or decoded from the state register only; there is no combinational path from inputs to outputs.
- States: IDLE, CAPTURE, DRAIN, REDIRECT, HANDLER, RETURN.
- IDLE:
  - exc_valid=1 → CAPTURE.
  - On that same edge: sepc_q<=exc_sepc, scause_q<=exc_scause, exc_count<=exc_count+1 (saturates at all-ones).
  - sret_req is ignored.
- CAPTURE (1 cycle):
  - exc_ack=1, flush_all=1.
  - Drain counter is loaded with DRAIN_CYCLES; next state is DRAIN.
- DRAIN:
  - flush_all=1; the counter decrements each cycle.
  - Leave for REDIRECT on the cycle the counter reaches 1. DRAIN therefore lasts exactly DRAIN_CYCLES cycles.
- REDIRECT (1 cycle):
  - trap_redirect=1, flush_all=1.
  - trap_target = HANDLER_BASE + (VECTORED ? {scause_q[3:0],2'b00} : 0).
  - The addition is mod 2^PC_W.
  - Next state is HANDLER.
- HANDLER:
  - in_handler=1.
  - exc_valid=1 → double_fault<=1, exc_ack pulses on the next cycle, sepc_q/scause_q are NOT overwritten, exc_count still increments, and the state stays HANDLER.
  - Otherwise sret_req=1 → RETURN.
  - If exc_valid and sret_req are high in the same cycle, the exception has priority and sret_req is dropped; software must re-issue it.
- RETURN (1 cycle):
  - trap_redirect=1, flush_all=1.
  - trap_target = sepc_q + 4, mod 2^PC_W (wrap: 15'h7FFC+4 → 0).
  - Next state is IDLE.
- exc_valid held high after exc_ack has been issued for the current exception is not re-accepted until it has been observed low for at least one cycle. Track this with an edge/armed flag.
- Latency: exc_valid rising edge → exc_ack at +1 cycle → trap_redirect at +(2+DRAIN_CYCLES) cycles.
- double_fault clears only on reset.

Decomposition:
- Shared package trap_pkg holds:
  - state enum trap_state_t {IDLE, CAPTURE, DRAIN, REDIRECT, HANDLER, RETURN};
  - constant HANDLER_BASE_DEFAULT;
  - cause-field localparams (e.g. CAUSE_ILLEGAL, CAUSE_MISALIGNED).
- One natural sub-module: trap_sat_counter, a parameterised saturating counter used for exc_count.
- The drain counter stays inline.

Test Plan:
1. Reset, then exc_valid=1, sepc=15'h0040, scause=32'h2 → exc_ack at +1; flush_all high +1..+5; trap_redirect at +5 with trap_target=15'h0108; sepc_q=15'h0040; exc_count=1.
2. Continue from (1), assert sret_req in HANDLER → next cycle trap_redirect=1, trap_target=15'h0044, then IDLE with in_handler=0.
3. In HANDLER, exc_valid with scause=5 and sret_req in the same cycle → double_fault=1; scause_q stays 2; no RETURN; exc_count=2; a later sret_req → target 15'h0044.
4. sepc=15'h7FFC, then sret → trap_target=15'h0000 (wrap). Set VECTORED=0 → handler target=15'h0100 for any cause.
5. Pull reset_n low during DRAIN → next edge: state IDLE, all outputs 0, no trap_redirect; exc_valid held high across reset is accepted fresh once reset_n=1.
6. Drive 300 back-to-back exception/return pairs → exc_count saturates at 8'hFF; exc_valid held high continuously yields exactly one ack per low→high transition.

Source files
------------

// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - shared types and constants for the trap responder
package trap_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        DRAIN,
        REDIRECT,
        HANDLER,
        RETURN
    } trap_state_t;

    localparam logic [14:0] HANDLER_BASE_DEFAULT = 15'h0100;

    localparam logic [31:0] CAUSE_MISALIGNED = 32'd0;
    localparam logic [31:0] CAUSE_ILLEGAL    = 32'd2;
    localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;

endpackage

// File: rtl/trap_responder_if.sv
// rtl/trap_responder_if.sv - exception request/acknowledge handshake between CPU and responder
interface trap_responder_if #(
    parameter int PC_W    = 15,
    parameter int CAUSE_W = 32
);
    logic               exc_valid;
    logic [PC_W-1:0]    exc_sepc;
    logic [CAUSE_W-1:0] exc_scause;
    logic               sret_req;
    logic               exc_ack;

    modport master (
        output exc_valid, exc_sepc, exc_scause, sret_req,
        input  exc_ack
    );

    modport slave (
        input  exc_valid, exc_sepc, exc_scause, sret_req,
        output exc_ack
    );
endinterface

// File: rtl/trap_sat_counter.sv
// rtl/trap_sat_counter.sv - saturating up-counter
module trap_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] count
);
    // Count increments and stick at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end
endmodule

// File: rtl/trap_responder.sv
// rtl/trap_responder.sv - exception responder: capture, drain, redirect, handler tracking, return
module trap_responder
    import trap_pkg::*;
#(
    parameter int              PC_W         = 15,
    parameter int              CAUSE_W      = 32,
    parameter logic [PC_W-1:0] HANDLER_BASE = PC_W'(HANDLER_BASE_DEFAULT),
    parameter bit              VECTORED     = 1'b1,
    parameter int              DRAIN_CYCLES = 3,
    parameter int              CNT_W        = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    trap_responder_if.slave    exc,
    output logic               flush_all,
    output logic               trap_redirect,
    output logic [PC_W-1:0]    trap_target,
    output logic               in_handler,
    output logic [PC_W-1:0]    sepc_q,
    output logic [CAUSE_W-1:0] scause_q,
    output logic [CNT_W-1:0]   exc_count,
    output logic               double_fault
);
    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

    trap_state_t     state;
    logic [3:0]      drain_cnt;
    logic            armed;
    logic            take;
    logic [PC_W-1:0] vec_offset;
    logic [PC_W-1:0] handler_target;

    // A request is taken only where the FSM listens and only once per low-to-high edge
    assign take = exc.exc_valid && armed && ((state == IDLE) || (state == HANDLER));

    assign vec_offset     = VECTORED ? {{(PC_W-6){1'b0}}, scause_q[3:0], 2'b00} : '0;
    assign handler_target = HANDLER_BASE + vec_offset;

    trap_sat_counter #(.W(CNT_W)) u_exc_count (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (take),
        .count   (exc_count)
    );

    // Trap FSM with registered strobes, drain timer and re-arm tracking
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            drain_cnt     <= '0;
            armed         <= 1'b1;
            exc.exc_ack   <= 1'b0;
            flush_all     <= 1'b0;
            trap_redirect <= 1'b0;
            trap_target   <= '0;
            in_handler    <= 1'b0;
            sepc_q        <= '0;
            scause_q      <= '0;
            double_fault  <= 1'b0;
        end else begin
            exc.exc_ack   <= 1'b0;
            trap_redirect <= 1'b0;
            trap_target   <= '0;

            if (take) begin
                armed <= 1'b0;
            end else if (!exc.exc_valid) begin
                armed <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (take) begin
                        state       <= CAPTURE;
                        sepc_q      <= exc.exc_sepc;
                        scause_q    <= exc.exc_scause;
                        exc.exc_ack <= 1'b1;
                        flush_all   <= 1'b1;
                    end
                end
                CAPTURE: begin
                    state     <= DRAIN;
                    drain_cnt <= DRAIN_INIT;
                    flush_all <= 1'b1;
                end
                DRAIN: begin
                    if (drain_cnt == 4'd1) begin
                        state         <= REDIRECT;
                        trap_redirect <= 1'b1;
                        trap_target   <= handler_target;
                    end else begin
                        drain_cnt <= drain_cnt - 4'd1;
                    end
                end
                REDIRECT: begin
                    state      <= HANDLER;
                    flush_all  <= 1'b0;
                    in_handler <= 1'b1;
                end
                HANDLER: begin
                    if (take) begin
                        double_fault <= 1'b1;
                        exc.exc_ack  <= 1'b1;
                    end else if (exc.sret_req) begin
                        state         <= RETURN;
                        in_handler    <= 1'b0;
                        trap_redirect <= 1'b1;
                        trap_target   <= sepc_q + PC_W'(4);
                        flush_all     <= 1'b1;
                    end
                end
                RETURN: begin
                    state     <= IDLE;
                    flush_all <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_trap_responder.sv
// tb/tb_trap_responder.sv - self-checking bench for trap_responder
module tb_trap_responder;
    import trap_pkg::*;

    localparam int PC_W    = 15;
    localparam int CAUSE_W = 32;
    localparam int CNT_W   = 8;
    localparam int D       = 3;
    localparam int BASE    = 'h100;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    trap_responder_if #(.PC_W(PC_W), .CAUSE_W(CAUSE_W)) bus0 ();
    trap_responder_if #(.PC_W(PC_W), .CAUSE_W(CAUSE_W)) bus1 ();

    assign bus1.exc_valid  = bus0.exc_valid;
    assign bus1.exc_sepc   = bus0.exc_sepc;
    assign bus1.exc_scause = bus0.exc_scause;
    assign bus1.sret_req   = bus0.sret_req;

    logic               flush0, redir0, inh0, df0;
    logic [PC_W-1:0]    tgt0, sepc0;
    logic [CAUSE_W-1:0] cause0;
    logic [CNT_W-1:0]   cnt0;
    logic               flush1, redir1, inh1, df1;
    logic [PC_W-1:0]    tgt1, sepc1;
    logic [CAUSE_W-1:0] cause1;
    logic [CNT_W-1:0]   cnt1;

    trap_responder #(.VECTORED(1'b1), .DRAIN_CYCLES(D)) dut0 (
        .clk(clk), .reset_n(reset_n), .exc(bus0),
        .flush_all(flush0), .trap_redirect(redir0), .trap_target(tgt0),
        .in_handler(inh0), .sepc_q(sepc0), .scause_q(cause0),
        .exc_count(cnt0), .double_fault(df0)
    );

    trap_responder #(.VECTORED(1'b0), .DRAIN_CYCLES(D)) dut1 (
        .clk(clk), .reset_n(reset_n), .exc(bus1),
        .flush_all(flush1), .trap_redirect(redir1), .trap_target(tgt1),
        .in_handler(inh1), .sepc_q(sepc1), .scause_q(cause1),
        .exc_count(cnt1), .double_fault(df1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          m_count;
    logic [14:0] m_sepc;
    logic [31:0] m_cause;
    logic        m_df;

    function automatic logic [31:0] handler_target(input logic [31:0] cause, input bit vec);
        int t;
        t = BASE + (vec ? int'(cause % 16) * 4 : 0);
        return 32'(t % 32768);
    endfunction

    function automatic logic [31:0] return_target(input logic [14:0] sepc);
        return 32'((int'(sepc) + 4) % 32768);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},    32'(bus0.exc_ack), 0);
        check({tag, "_flush"},  32'(flush0), 0);
        check({tag, "_redir"},  32'(redir0), 0);
        check({tag, "_tgt"},    32'(tgt0), 0);
        check({tag, "_inh"},    32'(inh0), 0);
        check({tag, "_sepc"},   32'(sepc0), 0);
        check({tag, "_cause"},  cause0, 0);
        check({tag, "_cnt"},    32'(cnt0), 0);
        check({tag, "_df"},     32'(df0), 0);
        check({tag, "_redir1"}, 32'(redir1), 0);
    endtask

    task automatic take_exception(input logic [14:0] sepc, input logic [31:0] cause,
                                  input bit hold, output int acks);
        bus0.exc_valid  = 1'b1;
        bus0.exc_sepc   = sepc;
        bus0.exc_scause = cause;
        m_count = (m_count < 255) ? m_count + 1 : 255;
        m_sepc  = sepc;
        m_cause = cause;
        acks = 0;
        for (int k = 1; k <= D + 3; k++) begin
            tick();
            if (bus0.exc_ack === 1'b1) acks++;
            check("ack",        32'(bus0.exc_ack), 32'(k == 1));
            check("flush",      32'(flush0), 32'(k <= D + 2));
            check("redirect",   32'(redir0), 32'(k == D + 2));
            check("in_handler", 32'(inh0), 32'(k == D + 3));
            check("df",         32'(df0), 32'(m_df));
            if (k == 1) begin
                check("sepc_q",    32'(sepc0), 32'(m_sepc));
                check("scause_q",  cause0, m_cause);
                check("exc_count", 32'(cnt0), 32'(m_count));
                check("ack_nv",    32'(bus1.exc_ack), 1);
                if (!hold) bus0.exc_valid = 1'b0;
            end
            if (k == D + 2) begin
                check("target_vec",   32'(tgt0), handler_target(m_cause, 1'b1));
                check("redirect_nv",  32'(redir1), 1);
                check("target_nvec",  32'(tgt1), handler_target(m_cause, 1'b0));
            end
        end
    endtask

    task automatic do_return();
        bus0.sret_req = 1'b1;
        tick();
        bus0.sret_req = 1'b0;
        check("ret_redirect", 32'(redir0), 1);
        check("ret_target",   32'(tgt0), return_target(m_sepc));
        check("ret_target1",  32'(tgt1), return_target(m_sepc));
        check("ret_flush",    32'(flush0), 1);
        check("ret_inh",      32'(inh0), 0);
        tick();
        check("idle_redirect", 32'(redir0), 0);
        check("idle_flush",    32'(flush0), 0);
        check("idle_inh",      32'(inh0), 0);
    endtask

    initial begin
        int acks;
        logic [14:0] rs;
        logic [31:0] rc;

        bus0.exc_valid  = 1'b0;
        bus0.exc_sepc   = '0;
        bus0.exc_scause = '0;
        bus0.sret_req   = 1'b0;
        m_count = 0;
        m_sepc  = '0;
        m_cause = '0;
        m_df    = 1'b0;

        reset_n = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // Basic exception with vectored target
        take_exception(15'h0040, CAUSE_ILLEGAL, 1'b0, acks);
        check("acks_t1", 32'(acks), 1);

        // Exception in handler together with sret: exception wins, sret dropped
        bus0.exc_valid  = 1'b1;
        bus0.exc_sepc   = 15'h1234;
        bus0.exc_scause = 32'd5;
        bus0.sret_req   = 1'b1;
        m_count = (m_count < 255) ? m_count + 1 : 255;
        m_df    = 1'b1;
        tick();
        bus0.exc_valid = 1'b0;
        bus0.sret_req  = 1'b0;
        check("df_ack",      32'(bus0.exc_ack), 1);
        check("df_set",      32'(df0), 1);
        check("df_scause",   cause0, 32'd2);
        check("df_sepc",     32'(sepc0), 32'h0040);
        check("df_inh",      32'(inh0), 1);
        check("df_redirect", 32'(redir0), 0);
        check("df_count",    32'(cnt0), 32'(m_count));
        tick();
        check("df_ack_off",  32'(bus0.exc_ack), 0);
        check("df_no_ret",   32'(redir0), 0);
        check("df_still_in", 32'(inh0), 1);
        do_return();
        check("df_sticky", 32'(df0), 1);

        // Return address wraps around the PC space
        take_exception(15'h7FFC, $urandom, 1'b0, acks);
        do_return();

        // A few random exception/return pairs
        for (int i = 0; i < 4; i++) begin
            rs = 15'($urandom);
            rc = $urandom;
            take_exception(rs, rc, 1'b0, acks);
            do_return();
        end

        // Reset during DRAIN with exc_valid held high across reset
        bus0.exc_valid  = 1'b1;
        bus0.exc_sepc   = 15'($urandom);
        bus0.exc_scause = $urandom;
        tick();
        tick();
        check("pre_reset_flush", 32'(flush0), 1);
        reset_n = 1'b0;
        tick();
        m_count = 0;
        m_df    = 1'b0;
        check_all_zero("midreset");
        reset_n = 1'b1;
        take_exception(15'h0200, 32'd7, 1'b0, acks);
        check("acks_after_reset", 32'(acks), 1);
        do_return();

        // Back-to-back pairs with exc_valid held high: one ack per rising edge, count saturates
        for (int i = 0; i < 300; i++) begin
            rs = 15'($urandom);
            rc = $urandom;
            take_exception(rs, rc, 1'b1, acks);
            check("acks_held", 32'(acks), 1);
            do_return();
            tick();
            check("held_no_reaccept", 32'(bus0.exc_ack), 0);
            check("held_idle_flush",  32'(flush0), 0);
            bus0.exc_valid = 1'b0;
            tick();
        end
        check("sat_count", 32'(cnt0), 32'hFF);
        check("sat_df",    32'(df0), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
